// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 hex keypad emulator.
//                Holds the FSM state encoding, the named key codes for the
//                non-digit keys and the key code to {row, col} one-hot map.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // Named codes for the non-digit keys
   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_STAR = 4'd13;
   localparam logic [3:0] KEY_HASH = 4'd14;
   localparam logic [3:0] KEY_D    = 4'd15;

   // Width of the hold/gap cycle counter (parameters range up to 65535)
   localparam int CNT_W = 16;

   // One-hot position of a key on the matrix
   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
   } key_pos_t;

   // Layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D
   function automatic key_pos_t key_to_pos(input logic [3:0] code);
      key_pos_t   p;
      logic [1:0] r;
      logic [1:0] c;
      r = 2'd0;
      c = 2'd0;
      case (code)
         4'd1:     begin r = 2'd0; c = 2'd0; end
         4'd2:     begin r = 2'd0; c = 2'd1; end
         4'd3:     begin r = 2'd0; c = 2'd2; end
         KEY_A:    begin r = 2'd0; c = 2'd3; end
         4'd4:     begin r = 2'd1; c = 2'd0; end
         4'd5:     begin r = 2'd1; c = 2'd1; end
         4'd6:     begin r = 2'd1; c = 2'd2; end
         KEY_B:    begin r = 2'd1; c = 2'd3; end
         4'd7:     begin r = 2'd2; c = 2'd0; end
         4'd8:     begin r = 2'd2; c = 2'd1; end
         4'd9:     begin r = 2'd2; c = 2'd2; end
         KEY_C:    begin r = 2'd2; c = 2'd3; end
         KEY_STAR: begin r = 2'd3; c = 2'd0; end
         4'd0:     begin r = 2'd3; c = 2'd1; end
         KEY_HASH: begin r = 2'd3; c = 2'd2; end
         default:  begin r = 2'd3; c = 2'd3; end // KEY_D
      endcase
      p.row = 4'b0001 << r;
      p.col = 4'b0001 << c;
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_if
//  Description : Key request handshake bundle (valid/ready with a 4-bit code).
//                master : requester, drives key_code/key_valid
//                slave  : emulator, drives key_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface
`default_nettype wire

// File: rtl/keypad_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_fifo
//  Description : Small synchronous FIFO for queued key requests.
//  Ports       : clk, rst (async, active-high)
//                i_push/i_data : write request (ignored when full)
//                i_pop         : read request  (ignored when empty)
//                o_data        : head entry (valid when not empty)
//                o_full/o_empty: occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_push,
   input  wire logic [WIDTH-1:0] i_data,
   input  wire logic             i_pop,
   output logic      [WIDTH-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == c_depth);
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rptr];

   // Storage carries no reset; only pointers and count define validity
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emulator
//  Description : Emulates a 4x4 matrix keypad for an external scanner. Key
//                requests are queued, then each key is held pressed for
//                HOLD_CYCLES and released for GAP_CYCLES before the next one.
//  Ports       : clk, rst (async, active-high)
//                kif   : key request handshake (slave side)
//                col   : column drive from the scanner
//                row   : row sense lines, combinational from col during PRESS
//                s_row : registered, high while a key is pressed
//                busy  : queue non-empty or a press/release in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_CYCLES = 64,
   parameter int GAP_CYCLES  = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   keypad_if.slave         kif,
   input  wire logic [3:0] col,
   output logic      [3:0] row,
   output logic            s_row,
   output logic            busy
);

   localparam logic [CNT_W-1:0] c_hold_m1 = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_gap_m1  = CNT_W'(GAP_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       r_key_row;
   logic [3:0]       r_key_col;
   logic [3:0]       w_key_row_nxt;
   logic [3:0]       w_key_col_nxt;
   logic             r_fifo_seen;
   logic             w_pop;
   logic [3:0]       w_fifo_data;
   logic             w_full;
   logic             w_empty;
   key_pos_t         w_pos;

   keypad_fifo #(
      .WIDTH (4),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (kif.key_valid),
      .i_data  (kif.key_code),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign kif.key_ready = !w_full;
   assign w_pos         = key_to_pos(w_fifo_data);
   assign busy          = !w_empty || (r_state != ST_IDLE);

   // Next-state / counter logic
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_key_row_nxt = r_key_row;
      w_key_col_nxt = r_key_col;
      w_pop         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // r_fifo_seen delays the start by one cycle after the first
            // write, giving a press two edges after acceptance; when the
            // queue was already occupied it is set and IDLE lasts one cycle.
            if (r_fifo_seen && !w_empty) begin
               w_pop         = 1'b1;
               w_key_row_nxt = w_pos.row;
               w_key_col_nxt = w_pos.col;
               w_cnt_nxt     = c_hold_m1;
               w_state_nxt   = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (r_cnt == '0) begin
               w_cnt_nxt   = c_gap_m1;
               w_state_nxt = ST_RELEASE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_RELEASE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_key_row   <= '0;
         r_key_col   <= '0;
         r_fifo_seen <= 1'b0;
         s_row       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_key_row   <= w_key_row_nxt;
         r_key_col   <= w_key_col_nxt;
         r_fifo_seen <= !w_empty;
         s_row       <= (w_state_nxt == ST_PRESS);
      end
   end

   // Pure combinational path col -> row, like a real switch closure
   always_comb begin
      row = 4'b0000;
      if ((r_state == ST_PRESS) && ((col & r_key_col) != 4'b0000)) begin
         row = r_key_row;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_emulator
//  Description : Self-checking bench for keypad_emulator. Requests are issued
//                through keypad_if; each accepted key is pushed with its
//                predicted press-start cycle into a scoreboard queue. A monitor
//                acting as the scanner sweeps col, decodes row back to a key
//                code and checks start cycle, press length, row and code.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;
   import keypad_pkg::*;

   localparam int HOLD  = 8;
   localparam int GAP   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] col = 4'b0000;
   logic [3:0] row;
   logic       s_row;
   logic       busy;

   keypad_if kif();

   keypad_emulator #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .kif   (kif),
      .col   (col),
      .row   (row),
      .s_row (s_row),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Physical keypad layout, rows top to bottom, columns left to right
   int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{13, 0, 14, 15}};

   typedef struct {
      int code;
      int start;
   } exp_t;

   exp_t sbq[$];
   int   starts[$];
   int   last_start = -1000;
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] pos_row(input int code);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (layout[r][c] == code) return 4'(1 << r);
      return 4'b0000;
   endfunction

   function automatic logic [3:0] pos_col(input int code);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (layout[r][c] == code) return 4'(1 << c);
      return 4'b0000;
   endfunction

   function automatic int decode(input logic [3:0] r, input logic [3:0] c);
      int ri;
      int ci;
      ri = -1;
      ci = -1;
      for (int i = 0; i < 4; i++) begin
         if (r[i]) ri = i;
         if (c[i]) ci = i;
      end
      if (ri < 0 || ci < 0) return -1;
      return layout[ri][ci];
   endfunction

   // Scanner column drive: a one-hot sweep plus all-ones, zero and random
   always @(posedge clk) begin
      #1;
      case (cyc % 8)
         0, 1, 2, 3: col = 4'(1 << (cyc % 4));
         4:          col = 4'hF;
         6:          col = 4'h0;
         default:    col = 4'($urandom_range(0, 15));
      endcase
   end

   // Monitor / scanner model
   int       in_press = 0;
   int       plen = 0;
   int       dec_code = -1;
   exp_t     cur;
   logic [3:0] exp_row;

   always @(negedge clk) begin
      if (rst) begin
         in_press = 0;
      end else begin
         if (in_press != 0 && !s_row) begin
            check("press_len", plen, HOLD);
            check("scan_code", dec_code, cur.code);
            in_press = 0;
         end else if (in_press == 0 && s_row) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_press: s_row=1 with no queued key (cycle %0d)", cyc);
               cur.code  = -1;
               cur.start = cyc;
            end else begin
               cur = sbq.pop_front();
               check("press_start", cyc, cur.start);
            end
            in_press = 1;
            plen     = 0;
            dec_code = -1;
         end
         exp_row = 4'b0000;
         if (in_press != 0) begin
            plen++;
            if ((col & pos_col(cur.code)) != 4'b0000) exp_row = pos_row(cur.code);
            if (row != 4'b0000 && $onehot(col)) dec_code = decode(row, col);
         end
         check("row", row, exp_row);
      end
   end

   // Issue one request, waiting while the queue is full; called at a negedge
   task automatic push_key(input int code);
      int budget;
      int occ;
      int st;
      bit done;
      budget = 300;
      done   = 1'b0;
      kif.key_code  = 4'(code);
      kif.key_valid = 1'b1;
      while (!done) begin
         occ = 0;
         foreach (starts[i]) if (starts[i] > cyc) occ++;
         check("key_ready", int'(kif.key_ready), int'(occ < DEPTH));
         if (kif.key_ready) begin
            // accepted at the next edge; press starts two edges later, or
            // after the previous press plus its release and one idle cycle
            st = cyc + 1 + 2;
            if (last_start + HOLD + GAP + 1 > st) st = last_start + HOLD + GAP + 1;
            last_start = st;
            sbq.push_back('{code: code, start: st});
            starts.push_back(st);
            done = 1'b1;
         end else begin
            budget--;
            if (budget == 0) begin
               checks++;
               errors++;
               $display("FAIL push_timeout: key_ready=0 for 300 cycles, code %0d", code);
               done = 1'b1;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int budget;
      budget = 600;
      while ((busy || sbq.size() != 0 || in_press != 0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL idle_timeout: busy=%0d pending=%0d", busy, sbq.size());
      end
      repeat (2) @(negedge clk);
   endtask

   int six_codes [6] = '{2, 5, 9, 13, 0, 14};

   initial begin
      int budget;
      kif.key_valid = 1'b0;
      kif.key_code  = 4'd0;
      rst = 1'b1;
      #1;
      check("rst_ready", kif.key_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_row", row, 0);
      check("rst_srow", s_row, 0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_ready", kif.key_ready, 1);

      // single press of 5
      push_key(5);
      kif.key_valid = 1'b0;
      wait_idle();

      // key D, column sweep handled by the scanner drive
      push_key(int'(KEY_D));
      kif.key_valid = 1'b0;
      wait_idle();

      // back-to-back 1, A, 0
      push_key(1);
      push_key(int'(KEY_A));
      push_key(0);
      kif.key_valid = 1'b0;
      wait_idle();

      // six codes with valid held high: exercises full back-pressure
      for (int i = 0; i < 6; i++) push_key(six_codes[i]);
      kif.key_valid = 1'b0;
      wait_idle();

      // random codes with random spacing
      repeat (12) begin
         push_key(int'($urandom_range(0, 15)));
         kif.key_valid = 1'b0;
         repeat ($urandom_range(0, 25)) @(negedge clk);
      end
      wait_idle();

      // reset in the middle of a press with two keys still queued
      push_key(3);
      push_key(6);
      push_key(9);
      kif.key_valid = 1'b0;
      budget = 200;
      while (!(s_row && row != 4'b0000) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL press_wait_timeout: s_row=%0d row=%0d", s_row, row);
      end
      #2 rst = 1'b1;
      #1;
      check("midrst_row", row, 0);
      check("midrst_srow", s_row, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", kif.key_ready, 1);
      sbq.delete();
      starts.delete();
      last_start = -1000;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("after_rst_busy", busy, 0);
      repeat (30) @(negedge clk);
      check("after_rst_busy_late", busy, 0);
      check("after_rst_srow", s_row, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
